// File: rtl/mem_arbiter.sv
// Byte-serial RAM arbiter between the icache and the load/store buffer.
// Round-robin grant; multi-byte reads and writes are sequenced one byte per cycle.
module mem_arbiter #(
    parameter int unsigned IO_STALL_EN = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_in,
    input  logic        io_buffer_full,
    input  logic        ic_req,
    input  logic [31:0] ic_addr,
    output logic        ic_done,
    output logic [31:0] ic_data,
    input  logic        lsb_req,
    input  logic        lsb_we,
    input  logic [31:0] lsb_addr,
    input  logic [1:0]  lsb_width,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_addr,
    output logic        ram_wr
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] ic_data_q, ic_data_d;
    logic [31:0] lsb_rdata_q, lsb_rdata_d;
    logic        owner_q, owner_d;       // 1 = LSB owns the transfer
    logic        is_wr_q, is_wr_d;
    logic        last_grant_q, last_grant_d;  // 1 = LSB was granted last

    logic        grant_lsb;
    logic        stall;
    logic [2:0]  lsb_len;
    logic [31:0] fill;
    logic [31:0] wshift;

    // LSB wins unless the icache also asks and the LSB had the previous grant.
    assign grant_lsb = lsb_req & (~ic_req | ~last_grant_q);
    assign stall     = (IO_STALL_EN != 0) && (addr_q[17:16] == 2'b11) && io_buffer_full;
    assign wshift    = wdata_q >> {cnt_q, 3'b000};

    always_comb begin
        case (lsb_width)
            2'd0:    lsb_len = 3'd1;
            2'd1:    lsb_len = 3'd2;
            default: lsb_len = 3'd4;
        endcase
    end

    // Byte arriving now belongs to the address issued last cycle (cnt - 1).
    always_comb begin
        fill = buf_q;
        case (cnt_q)
            3'd1:    fill[7:0]   = ram_din;
            3'd2:    fill[15:8]  = ram_din;
            3'd3:    fill[23:16] = ram_din;
            3'd4:    fill[31:24] = ram_din;
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= StIdle;
            cnt_q        <= 3'd0;
            len_q        <= 3'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            buf_q        <= 32'd0;
            ic_data_q    <= 32'd0;
            lsb_rdata_q  <= 32'd0;
            owner_q      <= 1'b0;
            is_wr_q      <= 1'b0;
            last_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            buf_q        <= buf_d;
            ic_data_q    <= ic_data_d;
            lsb_rdata_q  <= lsb_rdata_d;
            owner_q      <= owner_d;
            is_wr_q      <= is_wr_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        buf_d        = buf_q;
        ic_data_d    = ic_data_q;
        lsb_rdata_d  = lsb_rdata_q;
        owner_d      = owner_q;
        is_wr_d      = is_wr_q;
        last_grant_d = last_grant_q;
        if (rdy_in) begin
            unique case (state_q)
                StIdle: begin
                    if (!flush_in && (ic_req || lsb_req)) begin
                        owner_d      = grant_lsb;
                        last_grant_d = grant_lsb;
                        addr_d       = grant_lsb ? lsb_addr : ic_addr;
                        wdata_d      = lsb_wdata;
                        len_d        = grant_lsb ? lsb_len : 3'd4;
                        is_wr_d      = grant_lsb & lsb_we;
                        cnt_d        = 3'd0;
                        buf_d        = 32'd0;
                        state_d      = (grant_lsb && lsb_we) ? StWrite : StRead;
                    end
                end
                StRead: begin
                    if (flush_in) begin
                        state_d = StIdle;
                        cnt_d   = 3'd0;
                    end else begin
                        if (cnt_q != 3'd0) buf_d = fill;
                        if (cnt_q == len_q) state_d = StDone;
                        else                cnt_d   = cnt_q + 3'd1;
                    end
                end
                StWrite: begin
                    if (!stall) begin
                        if (cnt_q == len_q - 3'd1) state_d = StDone;
                        else                       cnt_d   = cnt_q + 3'd1;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                    cnt_d   = 3'd0;
                    if (!is_wr_q && !flush_in) begin
                        if (owner_q) lsb_rdata_d = buf_q;
                        else         ic_data_d   = buf_q;
                    end
                end
            endcase
        end
    end

    always_comb begin
        ic_done   = rdy_in && (state_q == StDone) && !owner_q && !flush_in;
        lsb_done  = rdy_in && (state_q == StDone) && owner_q && !(flush_in && !is_wr_q);
        ic_data   = ic_done ? buf_q : ic_data_q;
        lsb_rdata = (lsb_done && !is_wr_q) ? buf_q : lsb_rdata_q;
        ram_addr  = 32'd0;
        ram_dout  = 8'd0;
        ram_wr    = 1'b0;
        if (state_q == StRead || state_q == StWrite) begin
            ram_addr = addr_q + {29'd0, cnt_q};
        end
        if (state_q == StWrite) begin
            ram_dout = wshift[7:0];
            ram_wr   = rdy_in && !stall;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: RAM byte model plus write/done scoreboards.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in, io_buffer_full;
    logic        ic_req, ic_done, lsb_req, lsb_we, lsb_done, ram_wr;
    logic [31:0] ic_addr, ic_data, lsb_addr, lsb_wdata, lsb_rdata, ram_addr;
    logic [1:0]  lsb_width;
    logic [7:0]  ram_din, ram_dout;

    typedef struct {logic [31:0] addr; logic [7:0] data;} wr_t;
    typedef struct {bit is_lsb; bit chk; logic [31:0] data;} dn_t;

    wr_t wq[$];
    dn_t dq[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int s_cyc;
    logic [31:0] s_addr;
    logic s_wr, s_ic_done, s_lsb_done;

`define CHK(tag, obs, exp) begin total++; assert ((obs) === (exp)) else begin bad++; \
    $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); end end

    mem_arbiter #(.IO_STALL_EN(1)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .io_buffer_full(io_buffer_full),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_data(ic_data),
        .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_addr(lsb_addr), .lsb_width(lsb_width),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_addr(ram_addr), .ram_wr(ram_wr)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        if (a >= 32'h100 && a <= 32'h103) return 8'((a[7:0] + 8'h01) * 8'h11);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a, input int n);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = ram_byte(a + 32'(i));
        return r;
    endfunction

    // Read data returns one cycle after its address.
    always @(posedge clk_in) ram_din <= ram_byte(ram_addr);

    task automatic tick();
        wr_t w;
        dn_t d;
        @(negedge clk_in);
        s_addr = ram_addr; s_wr = ram_wr; s_ic_done = ic_done; s_lsb_done = lsb_done;
        s_cyc = cyc;
        if (ram_wr) begin
            total++;
            assert (wq.size() > 0) else begin
                bad++; $error("FAIL unexpected_write observed=%0h@%0h expected=none",
                              ram_dout, ram_addr);
            end
            if (wq.size() > 0) begin
                w = wq.pop_front();
                `CHK("wr_addr", ram_addr, w.addr)
                `CHK("wr_data", ram_dout, w.data)
            end
        end
        if (ic_done || lsb_done) begin
            `CHK("done_excl", ic_done & lsb_done, 1'b0)
            total++;
            assert (dq.size() > 0) else begin
                bad++; $error("FAIL unexpected_done observed=ic%0b/lsb%0b expected=none",
                              ic_done, lsb_done);
            end
            if (dq.size() > 0) begin
                d = dq.pop_front();
                `CHK("done_owner", lsb_done, logic'(d.is_lsb))
                if (d.chk) `CHK("done_data", (d.is_lsb ? lsb_rdata : ic_data), d.data)
            end
        end
        @(posedge clk_in);
        cyc++;
        #1;
        if (s_ic_done) ic_req = 1'b0;
        if (s_lsb_done) lsb_req = 1'b0;
    endtask

    task automatic run_until_done(input int budget, output int c);
        bit found;
        found = 1'b0;
        c = -1;
        for (int i = 0; i < budget && !found; i++) begin
            tick();
            if (s_ic_done || s_lsb_done) begin
                found = 1'b1;
                c = s_cyc;
            end
        end
        total++;
        assert (found) else begin
            bad++; $error("FAIL done_timeout observed=none expected=done_within_%0d", budget);
        end
    endtask

    task automatic pulse_reset();
        rst_in = 1'b1;
        @(posedge clk_in);
        cyc++;
        #1;
        rst_in = 1'b0;
    endtask

    initial begin
        int g, c;
        int ca[4];
        rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; io_buffer_full = 1'b0;
        ic_req = 1'b0; ic_addr = 32'd0; lsb_req = 1'b0; lsb_we = 1'b0;
        lsb_addr = 32'd0; lsb_width = 2'd0; lsb_wdata = 32'd0;
        repeat (2) @(posedge clk_in);
        #1;
        `CHK("rst_ram_addr", ram_addr, 32'd0)
        `CHK("rst_ram_wr", ram_wr, 1'b0)
        `CHK("rst_ram_dout", ram_dout, 8'd0)
        `CHK("rst_ic_done", ic_done, 1'b0)
        `CHK("rst_lsb_done", lsb_done, 1'b0)
        `CHK("rst_ic_data", ic_data, 32'd0)
        `CHK("rst_lsb_rdata", lsb_rdata, 32'd0)
        rst_in = 1'b0;

        // Icache word read with the documented byte pattern.
        ic_addr = 32'h100; ic_req = 1'b1;
        dq.push_back('{is_lsb: 1'b0, chk: 1'b1, data: 32'h44332211});
        tick();
        g = cyc;
        for (int k = 1; k <= 4; k++) begin
            tick();
            `CHK("ic_read_addr", s_addr, 32'h100 + 32'(k - 1))
        end
        run_until_done(10, c);
        `CHK("ic_done_cycle", c - g + 1, 6)
        tick();
        `CHK("ic_data_hold", ic_data, 32'h44332211)

        // Contention after reset: LSB first, then strict alternation.
        pulse_reset();
        lsb_addr = 32'h200; lsb_we = 1'b0; lsb_width = 2'd0; ic_addr = 32'h104;
        lsb_req = 1'b1; ic_req = 1'b1;
        dq.push_back('{is_lsb: 1'b1, chk: 1'b1, data: {24'd0, ram_byte(32'h200)}});
        dq.push_back('{is_lsb: 1'b0, chk: 1'b1, data: exp_read(32'h104, 4)});
        for (int i = 0; i < 4; i++) begin
            run_until_done(20, c);
            ca[i] = c;
            if (i == 0) begin
                lsb_req = 1'b1;
                dq.push_back('{is_lsb: 1'b1, chk: 1'b1, data: {24'd0, ram_byte(32'h200)}});
            end
            if (i == 1) begin
                ic_req = 1'b1;
                dq.push_back('{is_lsb: 1'b0, chk: 1'b1, data: exp_read(32'h104, 4)});
            end
        end
        `CHK("ic_after_lsb_gap", ca[1] - ca[0], 7)
        `CHK("lsb_after_ic_gap", ca[2] - ca[1], 4)

        // Half store to the I/O region, stalled three cycles by a full UART buffer.
        lsb_we = 1'b1; lsb_addr = 32'h30000; lsb_width = 2'd1; lsb_wdata = 32'h0000BEEF;
        io_buffer_full = 1'b1;
        wq.push_back('{addr: 32'h30000, data: 8'hEF});
        wq.push_back('{addr: 32'h30001, data: 8'hBE});
        dq.push_back('{is_lsb: 1'b1, chk: 1'b0, data: 32'd0});
        lsb_req = 1'b1;
        tick();
        g = cyc;
        for (int k = 0; k < 3; k++) begin
            tick();
            `CHK("io_stall_wr", s_wr, 1'b0)
        end
        io_buffer_full = 1'b0;
        run_until_done(10, c);
        `CHK("io_store_done_cycle", c - g + 1, 6)

        // Flush during cycle 2 of an icache read, then a fresh read.
        ic_addr = 32'h100; ic_req = 1'b1;
        tick();
        tick();
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0; ic_req = 1'b0;
        tick();
        `CHK("flush_idle_addr", s_addr, 32'd0)
        repeat (4) tick();
        ic_addr = 32'h108; ic_req = 1'b1;
        dq.push_back('{is_lsb: 1'b0, chk: 1'b1, data: exp_read(32'h108, 4)});
        run_until_done(12, c);

        // Flush during a word store must not abort it.
        lsb_we = 1'b1; lsb_addr = 32'h200; lsb_width = 2'd2; lsb_wdata = 32'hA1B2C3D4;
        wq.push_back('{addr: 32'h200, data: 8'hD4});
        wq.push_back('{addr: 32'h201, data: 8'hC3});
        wq.push_back('{addr: 32'h202, data: 8'hB2});
        wq.push_back('{addr: 32'h203, data: 8'hA1});
        dq.push_back('{is_lsb: 1'b1, chk: 1'b0, data: 32'd0});
        lsb_req = 1'b1;
        tick();
        tick();
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        run_until_done(10, c);
        `CHK("flush_store_all_bytes", wq.size(), 0)

        // Asynchronous reset in the middle of a read.
        ic_addr = 32'h100; ic_req = 1'b1;
        repeat (3) tick();
        #2;
        rst_in = 1'b1;
        #1;
        `CHK("midrst_ram_addr", ram_addr, 32'd0)
        `CHK("midrst_ic_done", ic_done, 1'b0)
        `CHK("midrst_ram_wr", ram_wr, 1'b0)
        `CHK("midrst_ic_data", ic_data, 32'd0)
        `CHK("midrst_lsb_rdata", lsb_rdata, 32'd0)
        ic_req = 1'b0;
        @(posedge clk_in);
        cyc++;
        #1;
        rst_in = 1'b0;
        repeat (4) tick();

        // rdy_in low for five cycles after the first byte of a word store.
        lsb_we = 1'b1; lsb_addr = 32'h400; lsb_width = 2'd2; lsb_wdata = 32'h11223344;
        wq.push_back('{addr: 32'h400, data: 8'h44});
        wq.push_back('{addr: 32'h401, data: 8'h33});
        wq.push_back('{addr: 32'h402, data: 8'h22});
        wq.push_back('{addr: 32'h403, data: 8'h11});
        dq.push_back('{is_lsb: 1'b1, chk: 1'b0, data: 32'd0});
        lsb_req = 1'b1;
        tick();
        g = cyc;
        tick();
        rdy_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            `CHK("frozen_wr", s_wr, 1'b0)
            `CHK("frozen_addr", s_addr, 32'h401)
        end
        rdy_in = 1'b1;
        run_until_done(10, c);
        `CHK("frozen_done_cycle", c - g + 1, 10)

        `CHK("wq_empty", wq.size(), 0)
        `CHK("dq_empty", dq.size(), 0)
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
